// File: rtl/merge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : merge_pkg
// Description : Shared types and constants for the ping-pong sprite merge
//               stage: buffer-state encoding, default transparency key and
//               pixel-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package merge_pkg;

  // Life cycle of one line buffer.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_t;

  // Magenta: the classic "no sprite here" colour for 8-bit channels.
  localparam logic [23:0] C_TRANSP_KEY_DEFAULT = 24'hFF00FF;

  // A pixel is packed {R,G,B}.
  function automatic int pixel_w(input int color_w);
    return 3 * color_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_priority_mux.sv
`default_nettype none
// ============================================================================
// Module      : pixel_priority_mux
// Description : Combinational merge of one background pixel with N sprite
//               layers. Layer 0 has the highest priority; a layer counts only
//               when it is active and its colour differs from the key.
// Ports       : bg_rgb     - background pixel
//               sp_rgb     - sprite pixels, layer i at [i*PW +: PW]
//               sp_active  - per-layer coverage
//               merged_rgb - winning pixel
//               overlap    - layer i is opaque together with another layer
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_priority_mux
  import merge_pkg::*;
#(
  parameter int                          COLOR_W    = 8,
  parameter int                          N_SPRITES  = 4,
  parameter logic [pixel_w(COLOR_W)-1:0] TRANSP_KEY = C_TRANSP_KEY_DEFAULT
) (
  input  logic [pixel_w(COLOR_W)-1:0]           bg_rgb,
  input  logic [N_SPRITES*pixel_w(COLOR_W)-1:0] sp_rgb,
  input  logic [N_SPRITES-1:0]                  sp_active,
  output logic [pixel_w(COLOR_W)-1:0]           merged_rgb,
  output logic [N_SPRITES-1:0]                  overlap
);

  localparam int                 PW    = pixel_w(COLOR_W);
  localparam logic [N_SPRITES-1:0] C_ONE = 1;

  logic [N_SPRITES-1:0] w_opaque;

  generate
    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_layer
      assign w_opaque[gi] = sp_active[gi] && (sp_rgb[gi*PW +: PW] != TRANSP_KEY);
      // Any opaque layer other than this one at the same position.
      assign overlap[gi]  = w_opaque[gi] && (|(w_opaque & ~(C_ONE << gi)));
    end
  endgenerate

  // Walk from lowest to highest priority so the lowest-index opaque layer
  // is the last assignment and wins.
  always_comb begin
    merged_rgb = bg_rgb;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (w_opaque[i]) merged_rgb = sp_rgb[i*PW +: PW];
    end
  end

endmodule
`default_nettype wire

// File: rtl/merge_pingpong_n.sv
`default_nettype none
// ============================================================================
// Module      : merge_pingpong_n
// Description : Merges background + N sprite layers per accepted pixel and
//               stores the result into a ping-pong pair of DEPTH-pixel line
//               buffers with per-buffer sprite collision flags.
// Ports       : clk, reset (async, active-low)
//               in_valid/in_ready, bg_rgb, sp_rgb, sp_active - pixel input
//               flush      - discard the partially filled write buffer
//               rd_avail   - a full buffer is readable
//               rd_addr    - read index, rd_rgb valid one cycle later
//               rd_release - reader done with the current buffer
//               collision  - overlap flags of the readable buffer
// Revision    : 1.0 - initial release
// ============================================================================
module merge_pingpong_n
  import merge_pkg::*;
#(
  parameter int                          COLOR_W    = 8,
  parameter int                          N_SPRITES  = 4,
  parameter int                          DEPTH      = 16,
  parameter logic [pixel_w(COLOR_W)-1:0] TRANSP_KEY = C_TRANSP_KEY_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [pixel_w(COLOR_W)-1:0]           bg_rgb,
  input  logic [N_SPRITES*pixel_w(COLOR_W)-1:0] sp_rgb,
  input  logic [N_SPRITES-1:0]                  sp_active,
  input  logic                                  flush,
  output logic                                  rd_avail,
  input  logic [$clog2(DEPTH)-1:0]              rd_addr,
  output logic [pixel_w(COLOR_W)-1:0]           rd_rgb,
  input  logic                                  rd_release,
  output logic [N_SPRITES-1:0]                  collision
);

  localparam int              PW         = pixel_w(COLOR_W);
  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW-1:0]   C_LAST_IDX = AW'(DEPTH - 1);

  buf_state_t           r_state     [2];
  buf_state_t           w_state_nxt [2];
  logic [N_SPRITES-1:0] r_coll      [2];
  logic [N_SPRITES-1:0] w_coll_nxt  [2];
  logic                 r_wr_buf, w_wr_buf_nxt;
  logic                 r_rd_buf, w_rd_buf_nxt;
  logic [AW-1:0]        r_wr_idx, w_wr_idx_nxt;
  logic [PW-1:0]        r_mem [2*DEPTH];
  logic [PW-1:0]        r_rd_rgb;

  logic [PW-1:0]        w_merged;
  logic [N_SPRITES-1:0] w_overlap;
  logic                 w_accept;
  logic                 w_write;

  pixel_priority_mux #(
    .COLOR_W    (COLOR_W),
    .N_SPRITES  (N_SPRITES),
    .TRANSP_KEY (TRANSP_KEY)
  ) u_mux (
    .bg_rgb     (bg_rgb),
    .sp_rgb     (sp_rgb),
    .sp_active  (sp_active),
    .merged_rgb (w_merged),
    .overlap    (w_overlap)
  );

  assign w_accept = in_valid && in_ready;
  // A flush in the same cycle wins: the offered pixel is consumed but dropped.
  assign w_write  = w_accept && !flush;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_coll[0]  <= '0;
      r_coll[1]  <= '0;
      r_wr_buf   <= 1'b0;
      r_rd_buf   <= 1'b0;
      r_wr_idx   <= '0;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      r_coll[0]  <= w_coll_nxt[0];
      r_coll[1]  <= w_coll_nxt[1];
      r_wr_buf   <= w_wr_buf_nxt;
      r_rd_buf   <= w_rd_buf_nxt;
      r_wr_idx   <= w_wr_idx_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Write and release always target different buffers
  // (the read buffer is FULL, the write buffer is not while accepting), so
  // both updates can be applied in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    w_coll_nxt[0]  = r_coll[0];
    w_coll_nxt[1]  = r_coll[1];
    w_wr_buf_nxt   = r_wr_buf;
    w_rd_buf_nxt   = r_rd_buf;
    w_wr_idx_nxt   = r_wr_idx;

    if (flush) begin
      if (r_state[r_wr_buf] == FILLING) begin
        w_state_nxt[r_wr_buf] = EMPTY;
        w_wr_idx_nxt          = '0;
      end
    end else if (w_accept) begin
      // The first pixel of a line replaces stale flags from an earlier use.
      if (r_state[r_wr_buf] == EMPTY) w_coll_nxt[r_wr_buf] = w_overlap;
      else                            w_coll_nxt[r_wr_buf] = r_coll[r_wr_buf] | w_overlap;

      if (r_wr_idx == C_LAST_IDX) begin
        w_state_nxt[r_wr_buf] = FULL;
        w_wr_buf_nxt          = ~r_wr_buf;
        w_wr_idx_nxt          = '0;
      end else begin
        w_state_nxt[r_wr_buf] = FILLING;
        w_wr_idx_nxt          = r_wr_idx + 1'b1;
      end
    end

    if (rd_release && rd_avail) begin
      w_state_nxt[r_rd_buf] = EMPTY;
      w_rd_buf_nxt          = ~r_rd_buf;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registered state only, so in_ready never sees rd_release
  // combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (r_state[r_wr_buf] != FULL);
    rd_avail  = (r_state[r_rd_buf] == FULL);
    collision = rd_avail ? r_coll[r_rd_buf] : '0;
    rd_rgb    = r_rd_rgb;
  end

  // --------------------------------------------------------------------------
  // Pixel storage (not reset) and registered read port.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_write) r_mem[{r_wr_buf, r_wr_idx}] <= w_merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_rd_rgb <= '0;
    else if (rd_avail) r_rd_rgb <= r_mem[{r_rd_buf, rd_addr}];
  end

endmodule
`default_nettype wire

// File: doc/merge_pingpong_n.md
Name: merge_pingpong_n

Overview:
Parametrised successor to the background/sprite merge stage. Merges one background pixel with N sprite layers per accepted input, using fixed priority and a transparency key. Writes the merged pixels into a ping-pong pair of line buffers, each DEPTH pixels long. The VGA read side gets per-pixel addressed access, a buffer-release handshake, and per-buffer sprite-overlap collision flags.

Parameters:
COLOR_W, 8, bits per colour channel; a pixel is 3*COLOR_W bits, packed {R,G,B}
N_SPRITES, 4, number of sprite layers; layer 0 has highest priority
DEPTH, 16, pixels per buffer; must be a power of two, at least 2
TRANSP_KEY, 24'hFF00FF, width 3*COLOR_W; sprite colour treated as transparent

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  merge can accept a pixel this cycle
bg_rgb  in  3*COLOR_W  background pixel
sp_rgb  in  N_SPRITES*3*COLOR_W  sprite pixels; layer i occupies bits [i*3*COLOR_W +: 3*COLOR_W]
sp_active  in  N_SPRITES  layer i covers this pixel position
flush  in  1  synchronous; discard the partially filled write buffer
rd_avail  out  1  a full buffer is readable
rd_addr  in  $clog2(DEPTH)  read pixel index
rd_rgb  out  3*COLOR_W  registered read data
rd_release  in  1  pulse; the reader is finished with the current buffer
collision  out  N_SPRITES  overlap flags belonging to the readable buffer

Behaviour:
- Reset: applies asynchronously and immediately, including mid-operation.
  - Both buffer states go to EMPTY; wr_buf=0, rd_buf=0, wr_idx=0.
  - Outputs after reset: rd_rgb=0, collision=0, rd_avail=0, in_ready=1.
  - Buffer pixel RAM is not reset.
- Per-buffer state: EMPTY -> FILLING on the first accept; FILLING -> FULL on the accept at wr_idx=DEPTH-1; FULL -> EMPTY on rd_release.
- Opaque test: layer i is opaque when sp_active[i]=1 and its sp_rgb slice != TRANSP_KEY.
- Merge: the merged pixel is the lowest-index opaque layer; if no layer is opaque, it is bg_rgb. This is combinational from the inputs.
- Overlap: overlap[i]=1 when layer i is opaque and at least one other layer is opaque at the same pixel.
- in_ready = (state[wr_buf] != FULL). It is derived from registered state only, with no combinational path from rd_release.
- Accept (in_valid && in_ready):
  - Write the merged pixel to buf[wr_buf][wr_idx] and OR overlap into coll[wr_buf].
  - If wr_idx=DEPTH-1: state[wr_buf] becomes FULL, wr_buf toggles, wr_idx returns to 0.
  - Otherwise wr_idx increments.
- The first accept into an EMPTY buffer replaces coll[wr_buf] with overlap rather than ORing into it.
- flush:
  - If state[wr_buf]=FILLING: state goes to EMPTY and wr_idx to 0.
  - Flush takes precedence over an accept in the same cycle; that pixel is dropped.
  - No effect on FULL buffers.
- rd_avail = (state[rd_buf]==FULL).
- Read latency is 1 cycle: rd_rgb <= buf[rd_buf][rd_addr] while rd_avail=1; otherwise rd_rgb holds its value.
- collision = coll[rd_buf] when rd_avail=1, otherwise 0.
- rd_release with rd_avail=1: state[rd_buf] becomes EMPTY and rd_buf toggles. rd_release with rd_avail=0 is ignored.
- Simultaneous events:
  - Release of one buffer and completion of the other in the same cycle both take effect.
  - A buffer freed this cycle accepts its first pixel the next cycle.
- With both buffers FULL, in_ready=0 and the input pixel must be held by the source.

Decomposition:
- Package merge_pkg holds:
  - the buffer-state enum {EMPTY, FILLING, FULL};
  - the default TRANSP_KEY;
  - a pixel-width constant or function of COLOR_W.
- Sub-module pixel_priority_mux (combinational). Inputs: bg_rgb, sp_rgb, sp_active. Outputs: merged pixel and overlap[N_SPRITES-1:0]. This keeps the top level limited to buffer, state and pointer logic.

Test Plan:
All scenarios use COLOR_W=8, N_SPRITES=4, DEPTH=16, TRANSP_KEY=24'hFF00FF.
1. Reset low then high -> in_ready=1, rd_avail=0, rd_rgb=0, collision=0.
2. Accept 16 pixels with bg=24'h205040 and sp_active=0 -> rd_avail=1 the cycle after the 16th accept. rd_addr=5 -> rd_rgb=24'h205040 one cycle later; collision=4'b0000.
3. Pixel 0 with sp_active=4'b0111, sp0=24'hFF00FF, sp1=24'h171717, sp2=24'h875032, then 15 background-only pixels -> rd_addr=0 reads 24'h171717 and collision=4'b0110.
4. Hold in_valid=1 for 33 pixels with no release -> in_ready=0 after 32 accepts, 33rd held. Pulse rd_release -> in_ready=1 the next cycle; the 33rd pixel lands in buffer 0 at index 0, and rd_avail stays 1 (buffer 1 is FULL).
5. Accept 7 pixels of 24'h111111, assert flush, then accept 16 pixels of 24'h222222 -> rd_avail after the 16th. rd_addr=0 reads 24'h222222; no 24'h111111 is present.
6. Drop reset mid-fill after 9 pixels -> rd_avail=0, collision=0, in_ready=1 immediately. A following 16-pixel fill completes normally.
